// File: rtl/mux_pkg.sv
// Shared encodings and index helpers for the stream multiplexers.
// Keeps the mode values identical across every datapath that selects by mode.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Wraps a channel index that may have run one step past n-1.
    function automatic int wrap_index(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

    function automatic int next_index(input int idx, input int n);
        return wrap_index(idx + 1, n);
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, modulo N.
// Holds no state; the pointer is owned by the caller.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!gnt_valid && (j == wrap_index(int'(ptr) + k, N)) && req[j]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 stream multiplexer with explicit-select and round-robin modes and a
// single registered output stage giving one-cycle latency at full throughput.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic [SELW-1:0]  ptr;
    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    logic             sel_hit;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             can_load;
    logic             in_xfer;
    logic             is_rr;

    assign is_rr = (mode_e'(mode) == MODE_RR);

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // A select value outside 0..N-1 matches no channel, so nothing is granted.
    always_comb begin
        sel_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                sel_hit = in_valid[i];
            end
        end
    end

    assign gnt_valid = is_rr ? rr_valid : sel_hit;
    assign gnt_idx   = is_rr ? rr_idx   : sel;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign in_xfer  = can_load && gnt_valid;

    // Gated by rst as well: the output stage is empty during reset, so can_load alone would open it.
    always_comb begin
        in_ready = '0;
        if (!rst && in_xfer) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_idx == SELW'(i)) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data register is reset too, because its value stays visible after the beat drains.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (can_load) begin
                out_valid <= gnt_valid;
                if (gnt_valid) begin
                    out_data <= gnt_data;
                    out_src  <= gnt_idx;
                end
            end
            if (in_xfer && is_rr) begin
                ptr <= SELW'(next_index(int'(gnt_idx), N));
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: vector table, directed corner cases,
// and a long randomized run against a queue-based reference model.
module tb_stream_mux_n;
    import mux_pkg::*;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;

    int checks = 0;
    int errors = 0;

    stream_mux_n #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mode;
        logic [2:0]  sel;
        logic [3:0]  valid;
        logic        ready;
        logic [3:0]  exp_ir;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  src;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];

    // Reference model state: output register contents and round-robin pointer.
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch_data(input int i);
        return in_data[i*WIDTH +: WIDTH];
    endfunction

    function automatic void ref_grant(input logic md, input int s, input logic [3:0] v,
                                      input int p, output bit found, output int idx);
        found = 1'b0;
        idx   = 0;
        if (md == MODE_SEL) begin
            if (s < N && v[s]) begin
                found = 1'b1;
                idx   = s;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && v[(p + k) % N]) begin
                    found = 1'b1;
                    idx   = (p + k) % N;
                end
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid  = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #2;
        rst       = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_src     = 0;
        m_ptr     = 0;
        sb.delete();
    endtask

    task automatic set_channels();
        for (int i = 0; i < N; i++) begin
            in_data[i*WIDTH +: WIDTH] = 32'hA5A5_0000 | 32'(i);
        end
    endtask

    // One model-checked cycle using whatever inputs are currently driven.
    task automatic run_cycle();
        bit         found;
        int         idx;
        bit         can;
        logic [3:0] exp_ir;
        beat_t      b;
        #1;
        ref_grant(mode, int'(sel), in_valid, m_ptr, found, idx);
        can    = !m_valid || out_ready;
        exp_ir = (can && found) ? 4'(1 << idx) : 4'b0;
        check("rnd_in_ready", 64'(in_ready), 64'(exp_ir));
        check("rnd_out_valid", 64'(out_valid), 64'(m_valid));
        check("rnd_out_data", 64'(out_data), 64'(m_data));
        check("rnd_out_src", 64'(out_src), 64'(m_src));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_beat", 64'(1), 64'(0));
            end else begin
                b = sb.pop_front();
                check("sb_data", 64'(out_data), 64'(b.data));
                check("sb_src", 64'(out_src), 64'(b.src));
            end
        end
        if (can && found) begin
            b.data = ch_data(idx);
            b.src  = SELW'(idx);
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        if (can) begin
            m_valid = found;
            if (found) begin
                m_data = b.data;
                m_src  = idx;
                if (mode == MODE_RR) m_ptr = (idx + 1) % N;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        mode      = MODE_SEL;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        set_channels();
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(0));
        check("reset_out_src", 64'(out_src), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(0));

        // Combinational grant table, each entry from the post-reset state (ptr=0, output empty).
        vecs.push_back('{MODE_SEL, 3'd2, 4'b1111, 1'b1, 4'b0100});
        vecs.push_back('{MODE_SEL, 3'd2, 4'b1011, 1'b1, 4'b0000});
        vecs.push_back('{MODE_SEL, 3'd0, 4'b0001, 1'b1, 4'b0001});
        vecs.push_back('{MODE_SEL, 3'd3, 4'b1000, 1'b0, 4'b1000});
        vecs.push_back('{MODE_SEL, 3'd5, 4'b1111, 1'b1, 4'b0000});
        vecs.push_back('{MODE_SEL, 3'd4, 4'b1111, 1'b1, 4'b0000});
        vecs.push_back('{MODE_RR,  3'd0, 4'b0000, 1'b1, 4'b0000});
        vecs.push_back('{MODE_RR,  3'd3, 4'b1010, 1'b1, 4'b0010});
        vecs.push_back('{MODE_RR,  3'd0, 4'b1000, 1'b0, 4'b1000});
        vecs.push_back('{MODE_RR,  3'd2, 4'b1111, 1'b1, 4'b0001});
        foreach (vecs[i]) begin
            do_reset();
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
        end

        // Explicit select of channel 2 with one-cycle latency.
        do_reset();
        mode = MODE_SEL; sel = 3'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        check("sel2_in_ready", 64'(in_ready), 64'(4'b0100));
        @(posedge clk); #1;
        check("sel2_out_valid", 64'(out_valid), 64'(1));
        check("sel2_out_data", 64'(out_data), 64'(32'hA5A5_0002));
        check("sel2_out_src", 64'(out_src), 64'(2));

        // Round-robin rotation from reset with wrap.
        do_reset();
        mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("rr_seq%0d_src", k), 64'(out_src), 64'(k % N));
            check($sformatf("rr_seq%0d_valid", k), 64'(out_valid), 64'(1));
        end

        // Held beat from ch1 under backpressure; pointer must sit at 2.
        do_reset();
        mode = MODE_RR; in_valid = 4'b0010; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_load_src", 64'(out_src), 64'(1));
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", k), 64'(out_valid), 64'(1));
            check($sformatf("hold%0d_data", k), 64'(out_data), 64'(32'hA5A5_0001));
            check($sformatf("hold%0d_src", k), 64'(out_src), 64'(1));
        end
        out_ready = 1'b1;
        #1;
        check("hold_release_in_ready", 64'(in_ready), 64'(4'b0100));
        @(posedge clk); #1;
        check("hold_release_src", 64'(out_src), 64'(2));

        // Out-of-range select: pending beat drains, then output goes idle with data retained.
        do_reset();
        mode = MODE_SEL; sel = 3'd0; in_valid = 4'b1111; out_ready = 1'b0;
        @(posedge clk); #1;
        sel = 3'd5;
        #1;
        check("oor_in_ready_held", 64'(in_ready), 64'(0));
        check("oor_valid_held", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("oor_drained_valid", 64'(out_valid), 64'(0));
        check("oor_drained_data", 64'(out_data), 64'(32'hA5A5_0000));
        check("oor_drained_src", 64'(out_src), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("oor_idle%0d_in_ready", k), 64'(in_ready), 64'(0));
            check($sformatf("oor_idle%0d_valid", k), 64'(out_valid), 64'(0));
        end

        // Asynchronous reset while a beat is stalled.
        do_reset();
        mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("arst_pre_src", 64'(out_src), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_data", 64'(out_data), 64'(0));
        check("arst_src", 64'(out_src), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("arst_first_grant", 64'(in_ready), 64'(4'b0001));
        @(posedge clk); #1;
        check("arst_first_src", 64'(out_src), 64'(0));

        // Randomized run against the reference model and scoreboard.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1) == 1 ? MODE_RR : MODE_SEL;
            if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, 5));
            run_cycle();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) run_cycle();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameter WIDTH, default 32: data width of every channel in bits.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N): width of sel and out_src.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, N: per-channel valid.
REQ-008 Port in_ready, output, N: per-channel ready; at most one bit high per cycle.
REQ-009 Port mode, input, 1: 0 = SEL (explicit select), 1 = RR (round-robin).
REQ-010 Port sel, input, SELW: channel index used in SEL mode.
REQ-011 Port out_data, output, WIDTH: registered selected data.
REQ-012 Port out_valid, output, 1: out_data/out_src hold a beat.
REQ-013 Port out_ready, input, 1: downstream accepts the beat.
REQ-014 Port out_src, output, SELW: index of the channel that produced the current beat.

Function
REQ-015 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both high; an output transfer SHALL occur where out_valid and out_ready are both high.
REQ-016 The output register SHALL be able to load when out_valid=0 or out_ready=1 (load-enable "can_load").
REQ-017 in_ready[i] SHALL be high only when can_load=1 and channel i is the grant; in_ready SHALL be combinational from in_valid, mode, sel, the RR pointer and out_ready.
REQ-018 SEL mode: grant = sel when in_valid[sel]=1; with sel >= N, no channel SHALL be granted and all in_ready SHALL be 0.
REQ-019 RR mode: grant = first channel with in_valid high, searching from pointer p upward modulo N.
REQ-020 After each RR input transfer on channel g, p SHALL become (g+1) mod N; wrap from N-1 to 0 is required; p SHALL NOT change in SEL mode or on cycles with no transfer.
REQ-021 Latency: an input beat accepted in cycle t SHALL appear on out_data/out_src with out_valid=1 in cycle t+1.
REQ-022 Throughput: with out_ready held at 1 and a grantable channel valid, one beat per cycle (back-to-back).
REQ-023 While out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-024 When out_valid=1, out_ready=1 and no grant exists, out_valid SHALL drop to 0 next cycle; out_data and out_src SHALL retain their last values.
REQ-025 A mode or sel change SHALL affect only the grant of the current and following cycles; the beat already in the output register SHALL be unaffected.
REQ-026 No input beat SHALL be duplicated or dropped under any combination of stalls, mode changes or sel changes.

Reset
REQ-027 On rst high, asynchronously: out_valid=0, out_data=0, out_src=0, p=0; in_ready SHALL be 0 while rst is high.
REQ-028 Reset asserted mid-transfer SHALL discard the held beat; the first cycle after release SHALL behave as the first cycle after power-up.

Structure
REQ-029 A shared package/header mux_pkg SHALL hold the mode encodings MODE_SEL=0 and MODE_RR=1 for reuse by datapath muxes.
REQ-030 The round-robin grant search SHALL be one combinational sub-module rr_arbiter (inputs req[N] and ptr; outputs gnt_valid and gnt_idx); pointer and output register live in stream_mux_n.

Verification
REQ-031 SEL mode, N=4, sel=2, in_valid=4'b1111, ch2=32'hA5A5_0002, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hA5A5_0002, out_src=2.
REQ-032 RR mode, all four valid every cycle, out_ready=1, from reset -> out_src sequence 0,1,2,3,0 on consecutive cycles (wrap checked).
REQ-033 RR, beat from ch1 held, out_ready=0 for 3 cycles -> out_data/out_src stable, in_ready=0, p=2 throughout; on release, next grant = ch2 if valid.
REQ-034 SEL mode, sel=5 with N=4, all valid -> in_ready=0 forever; out_valid falls to 0 after the pending beat drains.
REQ-035 rst pulsed while out_valid=1, out_ready=0 -> out_valid=0 and out_data=0 immediately (asynchronously); first RR grant after release = ch0.
REQ-036 Random valid/ready/mode/sel for 10k cycles against a scoreboard -> every accepted beat emitted exactly once, in order, with the correct out_src.
